alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer around an external combinational ALU.
// Holds an 8x32 register file (r0 hardwired to zero) and a result output handshake.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic [2:0]  out_rd,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] regs_q [8];
    logic [31:0] regs_d [8];
    logic [31:0] out_result_q, out_result_d;
    logic        out_zero_q, out_zero_d;
    logic [2:0]  out_rd_q, out_rd_d;

    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        use_imm;
    logic [15:0] imm;
    logic        unused_instr_bits;

    assign op      = instr_q[31:29];
    assign rd      = instr_q[28:26];
    assign rs1     = instr_q[25:23];
    assign rs2     = instr_q[22:20];
    assign use_imm = instr_q[19];
    assign imm     = instr_q[15:0];
    assign unused_instr_bits = ^instr_q[18:16];

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        regs_d       = regs_q;
        out_result_d = out_result_q;
        out_zero_d   = out_zero_q;
        out_rd_d     = out_rd_q;
        alu_a        = '0;
        alu_b        = '0;
        alu_op       = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_op = op;
                alu_a  = regs_q[rs1];
                alu_b  = use_imm ? {16'h0000, imm} : regs_q[rs2];
                // Result and register write are captured together on the way into WB.
                out_result_d = alu_result;
                out_zero_d   = alu_zero;
                out_rd_d     = rd;
                if (rd != 3'd0) begin
                    regs_d[rd] = alu_result;
                end
                state_d = WB;
            end
            WB: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            out_rd_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            out_result_q <= out_result_d;
            out_zero_q   <= out_zero_d;
            out_rd_q     <= out_rd_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == WB);
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;
    assign out_rd     = out_rd_q;
    assign dbg_data   = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

endmodule
